// File: rtl/alu_control_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_data_mem
// Description : EX-stage ALU control decoder and MEM-stage word-addressed
//               data memory (synchronous write, asynchronous read).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluOP,
    input  logic [5:0]  funct,
    output logic [3:0]  operation,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic        misaligned
);

    // ALU op classes from the main control unit
    localparam logic [1:0] c_ALUOP_MEM    = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;

    // R-type funct encodings
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_SLL = 6'b000000;
    localparam logic [5:0] c_FN_SRL = 6'b000010;

    // ALU operation codes
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_SLL = 4'b1000;
    localparam logic [3:0] c_OP_SRL = 4'b1001;

    logic [3:0]    w_operation;
    logic [AW-1:0] w_index;
    logic [31:0]   w_read_word;
    logic          w_unused_addr_bits;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    // ------------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_operation = c_OP_ADD;
        case (aluOP)
            c_ALUOP_MEM:    w_operation = c_OP_ADD;
            c_ALUOP_BRANCH: w_operation = c_OP_SUB;
            c_ALUOP_RTYPE: begin
                case (funct)
                    c_FN_ADD: w_operation = c_OP_ADD;
                    c_FN_SUB: w_operation = c_OP_SUB;
                    c_FN_AND: w_operation = c_OP_AND;
                    c_FN_OR:  w_operation = c_OP_OR;
                    c_FN_NOR: w_operation = c_OP_NOR;
                    c_FN_SLT: w_operation = c_OP_SLT;
                    c_FN_SLL: w_operation = c_OP_SLL;
                    c_FN_SRL: w_operation = c_OP_SRL;
                    default:  w_operation = c_OP_ADD;
                endcase
            end
            default:        w_operation = c_OP_ADD;
        endcase
    end

    assign operation = w_operation;

    // ------------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------------
    // Byte offset and high address bits are dropped, so accesses wrap.
    assign w_index            = address[AW+1:2];
    assign w_unused_addr_bits = &{1'b0, address[31:AW+2]};

    assign misaligned  = (memRead | memWrite) & (address[1:0] != 2'b00);
    assign w_read_word = mem_q[w_index];
    assign readData    = memRead ? w_read_word : 32'h0;

    always_comb begin
        mem_d = mem_q;
        if (memWrite) begin
            mem_d[w_index] = writeData;
        end
    end

    // Reset wins over a same-edge write by clearing the whole array.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: 32'h0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_data_mem
// Description : Self-checking bench: table-driven ALU decode plus a
//               scoreboarded sequence of memory accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_data_mem;

    logic        clk;
    logic        reset;
    logic [1:0]  aluOP;
    logic [5:0]  funct;
    logic [3:0]  operation;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readData;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } alu_vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        mis;
    } mem_exp_t;

    mem_exp_t sb_q[$];

    alu_control_data_mem #(
        .DEPTH (256),
        .AW    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aluOP      (aluOP),
        .funct      (funct),
        .operation  (operation),
        .address    (address),
        .writeData  (writeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .readData   (readData),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Drive one cycle of memory stimulus, push the expectation, then pop and
    // compare at the falling edge (before the write edge).
    task automatic access(input string name, input logic rst, input logic rd,
                          input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_mis);
        mem_exp_t e;
        reset     = rst;
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writeData = wdata;
        sb_q.push_back('{name, exp_rd, exp_mis});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (readData !== e.rd || misaligned !== e.mis) begin
                n_errors++;
                $display("FAIL %s: got readData=%h misaligned=%b, expected readData=%h misaligned=%b",
                         e.name, readData, misaligned, e.rd, e.mis);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        alu_vec_t vecs [12];
        vecs[0]  = '{2'b00, 6'h00, 4'b0010};
        vecs[1]  = '{2'b01, 6'h20, 4'b0110};
        vecs[2]  = '{2'b10, 6'h20, 4'b0010};
        vecs[3]  = '{2'b10, 6'h22, 4'b0110};
        vecs[4]  = '{2'b10, 6'h24, 4'b0000};
        vecs[5]  = '{2'b10, 6'h25, 4'b0001};
        vecs[6]  = '{2'b10, 6'h27, 4'b1100};
        vecs[7]  = '{2'b10, 6'h2A, 4'b0111};
        vecs[8]  = '{2'b10, 6'h00, 4'b1000};
        vecs[9]  = '{2'b10, 6'h02, 4'b1001};
        vecs[10] = '{2'b10, 6'h3F, 4'b0010};
        vecs[11] = '{2'b11, 6'h22, 4'b0010};

        reset     = 1'b1;
        aluOP     = 2'b00;
        funct     = 6'h00;
        address   = 32'h0;
        writeData = 32'h0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            aluOP = vecs[i].op;
            funct = vecs[i].fn;
            #1;
            n_checks++;
            if (operation !== vecs[i].exp) begin
                n_errors++;
                $display("FAIL alu_vec%0d (aluOP=%b funct=%h): got %b, expected %b",
                         i, vecs[i].op, vecs[i].fn, operation, vecs[i].exp);
            end
        end

        // Reset state, then write/read basics
        access("reset_read_10",   1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0);
        access("reset_read_3fc",  1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0);
        access("write_10",        1'b0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        access("read_10",         1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access("read_14",         1'b0, 1'b1, 1'b0, 32'h14,  32'h0,        32'h0,        1'b0);
        access("gated_10",        1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0);
        access("rw_same_cycle",   1'b0, 1'b1, 1'b1, 32'h10,  32'h12345678, 32'hDEADBEEF, 1'b0);
        access("read_after_rw",   1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0);

        // Wrap and misalignment
        access("write_wrap_400",  1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0,        1'b0);
        access("read_0_wrapped",  1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0);
        access("write_top_3fc",   1'b0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0);
        access("read_high_bits",  1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,   32'hCAFEF00D, 1'b0);
        access("read_mis_13",     1'b0, 1'b1, 1'b0, 32'h13,  32'h0,        32'h12345678, 1'b1);
        access("idle_13",         1'b0, 1'b0, 1'b0, 32'h13,  32'h0,        32'h0,        1'b0);
        access("write_mis_26",    1'b0, 1'b0, 1'b1, 32'h26,  32'h0BADF00D, 32'h0,        1'b1);
        access("read_24",         1'b0, 1'b1, 1'b0, 32'h24,  32'h0,        32'h0BADF00D, 1'b0);

        // Reset beats a same-edge write and clears earlier data
        access("reset_with_write", 1'b1, 1'b1, 1'b1, 32'h20, 32'h1,        32'h0,        1'b0);
        access("post_reset_20",   1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0);
        access("post_reset_10",   1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0);
        access("post_reset_0",    1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0);
        access("post_reset_3fc",  1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
